// File: rtl/mem_arb_pkg.sv
// Shared types and sizing for the Z80/video memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W           = 16;
  localparam int DATA_W           = 8;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int STREAK_W         = 4;

  typedef enum logic [2:0] {
    IDLE,
    CPU_RD,
    CPU_CAP,
    CPU_WR,
    VID_RD,
    VID_CAP
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Purpose: shares one synchronous memory port between a Z80 core and a video fetcher.
// Latency: CPU read 3 cycles, CPU write 2 cycles, video fetch 3 cycles to vid_ack.
// Backpressure: CPU stalls via cpu_wait_n; video waits on level vid_req, CPU wins after STARVE_LIMIT video grants.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_mreq_n,
  input  logic              cpu_rd_n,
  input  logic              cpu_wr_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_dout,
  output logic [DATA_W-1:0] cpu_di,
  output logic              cpu_wait_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

  arb_state_t          state;
  arb_state_t          state_nxt;
  logic                cpu_done;
  logic                cpu_pend;
  logic                vid_grant;
  logic [STREAK_W-1:0] streak;

  // Refresh cycles (mreq_n low, both strobes high) never count as pending.
  assign cpu_pend   = ~cpu_mreq_n & (~cpu_rd_n | ~cpu_wr_n) & ~cpu_done;
  assign cpu_wait_n = ~reset_n | ~cpu_pend;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
    mem_din   = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    vid_grant = 1'b0;
    case (state)
      IDLE: begin
        if (vid_req && (!cpu_pend || streak < LIMIT)) begin
          state_nxt = VID_RD;
          vid_grant = 1'b1;
        end else if (cpu_pend) begin
          // Both strobes low resolves to a read.
          state_nxt = cpu_rd_n ? CPU_WR : CPU_RD;
        end
      end
      CPU_RD: begin
        mem_addr  = cpu_addr;
        mem_rd    = 1'b1;
        state_nxt = CPU_CAP;
      end
      CPU_CAP: state_nxt = IDLE;
      CPU_WR: begin
        mem_addr  = cpu_addr;
        mem_din   = cpu_dout;
        mem_wr    = 1'b1;
        state_nxt = IDLE;
      end
      VID_RD: begin
        mem_addr  = vid_addr;
        mem_rd    = 1'b1;
        state_nxt = VID_CAP;
      end
      VID_CAP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cpu_done <= 1'b0;
      streak   <= '0;
      vid_ack  <= 1'b0;
      cpu_di   <= '0;
      vid_data <= '0;
    end else begin
      vid_ack <= (state == VID_CAP);
      if (state == VID_CAP) vid_data <= mem_dout;
      if (state == CPU_CAP) cpu_di   <= mem_dout;

      // One service per mreq_n assertion; done only drops when mreq_n rises.
      if (cpu_mreq_n)                                cpu_done <= 1'b0;
      else if (state == CPU_CAP || state == CPU_WR)  cpu_done <= 1'b1;

      // A video grant with CPU pending implies streak < LIMIT, so this saturates.
      if (state == IDLE) begin
        if (!cpu_pend)      streak <= '0;
        else if (vid_grant) streak <= streak + 4'd1;
        else                streak <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory plus scoreboard queues for video and CPU read data.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_mreq_n, cpu_rd_n, cpu_wr_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_di;
  logic        cpu_wait_n;
  logic        vid_req;
  logic [15:0] vid_addr;
  logic [7:0]  vid_data;
  logic        vid_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_dout = 8'h00;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [7:0] vid_q[$];
  logic [7:0] cpu_q[$];

  logic [7:0] wmem  [0:65535];
  bit         wflag [0:65535];

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_mreq_n(cpu_mreq_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_di(cpu_di), .cpu_wait_n(cpu_wait_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_ack(vid_ack),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Unwritten locations return a fixed address-derived pattern.
  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[15:8] ^ a[7:0] ^ 8'h83;
  endfunction

  always @(posedge clk) begin
    if (mem_wr) begin
      wmem[mem_addr]  <= mem_din;
      wflag[mem_addr] <= 1'b1;
    end
    if (mem_rd) mem_dout <= wflag[mem_addr] ? wmem[mem_addr] : pat(mem_addr);
  end

  // Port invariants and video scoreboard.
  always @(negedge clk) begin
    if (mem_rd || mem_wr) begin
      n_cmp++;
      if (mem_rd && mem_wr) begin
        n_fail++; $display("FAIL strobe_excl: mem_rd=%b mem_wr=%b, required not both", mem_rd, mem_wr);
      end
    end else begin
      n_cmp++;
      if (mem_addr !== 16'h0 || mem_din !== 8'h0) begin
        n_fail++; $display("FAIL idle_port_zero: addr=%h din=%h, required 0/0", mem_addr, mem_din);
      end
    end
    if (vid_ack) begin
      n_cmp++;
      if (vid_q.size() == 0) begin
        n_fail++; $display("FAIL vid_unexpected_ack: vid_data=%h at cycle %0d, required no ack", vid_data, cyc);
      end else begin
        logic [7:0] exp;
        exp = vid_q.pop_front();
        if (vid_data !== exp) begin
          n_fail++; $display("FAIL vid_data: got %h, required %h", vid_data, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cpu_release();
    cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
    tick(); tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0; cpu_wr_n = 1'b1;
    cpu_addr = 16'h0; cpu_dout = 8'h0; vid_req = 1'b0; vid_addr = 16'h0;
    repeat (3) tick();
    @(negedge clk);
    n_cmp++; if (cpu_wait_n !== 1'b1) begin n_fail++; $display("FAIL rst_wait_n: got %b, required 1", cpu_wait_n); end
    n_cmp++; if (mem_rd !== 1'b0)     begin n_fail++; $display("FAIL rst_mem_rd: got %b, required 0", mem_rd); end
    n_cmp++; if (mem_wr !== 1'b0)     begin n_fail++; $display("FAIL rst_mem_wr: got %b, required 0", mem_wr); end
    n_cmp++; if (vid_ack !== 1'b0)    begin n_fail++; $display("FAIL rst_vid_ack: got %b, required 0", vid_ack); end
    n_cmp++; if (cpu_di !== 8'h00)    begin n_fail++; $display("FAIL rst_cpu_di: got %h, required 00", cpu_di); end
    n_cmp++; if (vid_data !== 8'h00)  begin n_fail++; $display("FAIL rst_vid_data: got %h, required 00", vid_data); end
    cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1;
    tick();
    reset_n = 1'b1;
    tick(); tick();
  endtask

  task automatic test_cpu_read();
    tick();
    cpu_addr = 16'h1234; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    cpu_q.push_back(8'hA5);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      case (k)
        0: if (cpu_wait_n !== 1'b0) begin n_fail++; $display("FAIL rd_wait_n0: got %b, required 0", cpu_wait_n); end
        1: if ({mem_rd, mem_addr} !== {1'b1, 16'h1234}) begin
             n_fail++; $display("FAIL rd_strobe: rd=%b addr=%h, required 1/1234", mem_rd, mem_addr);
           end
        2: if ({mem_rd, cpu_wait_n} !== 2'b00) begin
             n_fail++; $display("FAIL rd_n2: rd=%b wait_n=%b, required 0/0", mem_rd, cpu_wait_n);
           end
        default: if (cpu_wait_n !== 1'b1 || cpu_q.size() == 0 || cpu_di !== cpu_q.pop_front()) begin
             n_fail++; $display("FAIL rd_data: wait_n=%b cpu_di=%h, required 1/a5", cpu_wait_n, cpu_di);
           end
      endcase
    end
    cpu_release();
  endtask

  task automatic test_cpu_write();
    int wcnt = 0;
    bit done = 0;
    tick();
    cpu_addr = 16'h8000; cpu_dout = 8'h5A; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0; cpu_rd_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (mem_wr) begin
        wcnt++;
        n_cmp++;
        if ({mem_addr, mem_din} !== {16'h8000, 8'h5A} || k != 1) begin
          n_fail++; $display("FAIL wr_strobe: addr=%h din=%h k=%0d, required 8000/5a k=1", mem_addr, mem_din, k);
        end
      end
      if (k == 2) begin
        n_cmp++;
        if (cpu_wait_n !== 1'b1) begin n_fail++; $display("FAIL wr_wait_n: got %b, required 1", cpu_wait_n); end
      end
    end
    n_cmp++;
    if (wcnt != 1) begin n_fail++; $display("FAIL wr_count: got %0d, required 1", wcnt); end
    cpu_release();
    // Read the location back through the arbiter.
    tick();
    cpu_addr = 16'h8000; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    cpu_q.push_back(8'h5A);
    for (int k = 0; k < 10 && !done; k++) begin
      @(negedge clk);
      if (cpu_wait_n) begin
        done = 1;
        n_cmp++;
        if (cpu_q.size() == 0 || cpu_di !== cpu_q.pop_front()) begin
          n_fail++; $display("FAIL wr_readback: got %h, required 5a", cpu_di);
        end
      end
    end
    if (!done) begin n_cmp++; n_fail++; $display("FAIL wr_readback_timeout: wait_n=%b, required 1", cpu_wait_n); end
    cpu_release();
  endtask

  task automatic test_refresh();
    bit any_strobe = 0;
    bit any_wait = 0;
    tick();
    cpu_addr = 16'h0077; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (mem_rd || mem_wr) any_strobe = 1;
      if (!cpu_wait_n) any_wait = 1;
    end
    n_cmp++; if (any_strobe) begin n_fail++; $display("FAIL refresh_strobe: got 1, required 0"); end
    n_cmp++; if (any_wait)   begin n_fail++; $display("FAIL refresh_wait: got wait_n=0, required 1"); end
    cpu_release();
  endtask

  task automatic test_both_strobes();
    bit saw_wr = 0;
    tick();
    cpu_addr = 16'h1234; cpu_dout = 8'hFF; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0; cpu_wr_n = 1'b0;
    cpu_q.push_back(8'hA5);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (mem_wr) saw_wr = 1;
      if (k == 1) begin
        n_cmp++;
        if (mem_rd !== 1'b1) begin n_fail++; $display("FAIL both_rd: mem_rd=%b, required 1", mem_rd); end
      end
      if (k == 3) begin
        n_cmp++;
        if (cpu_wait_n !== 1'b1 || cpu_q.size() == 0 || cpu_di !== cpu_q.pop_front()) begin
          n_fail++; $display("FAIL both_data: wait_n=%b cpu_di=%h, required 1/a5", cpu_wait_n, cpu_di);
        end
      end
    end
    n_cmp++; if (saw_wr) begin n_fail++; $display("FAIL both_no_wr: mem_wr seen, required none"); end
    cpu_release();
  endtask

  task automatic test_starvation();
    int  acks = 0;
    int  cpu_k = 0;
    bit  cpu_seen = 0;
    bit  resumed = 0;
    tick();
    vid_addr = 16'h2000; vid_req = 1'b1; vid_q.push_back(pat(16'h2000));
    cpu_addr = 16'h1100; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    cpu_q.push_back(pat(16'h1100));
    for (int k = 0; k < 60 && !resumed; k++) begin
      @(negedge clk);
      if (!cpu_seen && cpu_wait_n) begin
        cpu_seen = 1; cpu_k = k;
        n_cmp++;
        if (acks != 4) begin n_fail++; $display("FAIL starve_acks: got %0d, required 4", acks); end
        n_cmp++;
        if (cpu_q.size() == 0 || cpu_di !== cpu_q.pop_front()) begin
          n_fail++; $display("FAIL starve_cpu_data: got %h, required 92", cpu_di);
        end
        cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1;
      end
      if (vid_ack) begin
        acks++;
        if (cpu_seen) begin
          resumed = 1;
          n_cmp++;
          if (k - cpu_k != 3) begin n_fail++; $display("FAIL starve_resume: got %0d cycles, required 3", k - cpu_k); end
          vid_req = 1'b0;
        end else begin
          vid_q.push_back(pat(16'h2000));
        end
      end
    end
    if (!resumed) begin
      n_cmp++; n_fail++; $display("FAIL starve_timeout: acks=%0d cpu_seen=%0d, required resume", acks, cpu_seen);
      vid_req = 1'b0; cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1;
    end
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int prev = 0;
    tick();
    vid_addr = 16'h4000; vid_req = 1'b1; vid_q.push_back(pat(16'h4000));
    for (int k = 0; k < 40 && n < 4; k++) begin
      @(negedge clk);
      if (vid_ack) begin
        if (n > 0) begin
          n_cmp++;
          if (cyc - prev != 3) begin n_fail++; $display("FAIL b2b_spacing: got %0d, required 3", cyc - prev); end
        end
        prev = cyc;
        n++;
        if (n < 4) begin
          vid_addr = 16'h4000 + 16'(n);
          vid_q.push_back(pat(vid_addr));
        end else begin
          vid_req = 1'b0;
        end
      end
    end
    if (n < 4) begin
      n_cmp++; n_fail++; $display("FAIL b2b_timeout: got %0d acks, required 4", n);
      vid_req = 1'b0;
    end
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    int late_acks = 0;
    tick();
    vid_addr = 16'h4002; vid_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({mem_rd, mem_addr} !== {1'b1, 16'h4002}) begin
      n_fail++; $display("FAIL rstmid_vid_rd: rd=%b addr=%h, required 1/4002", mem_rd, mem_addr);
    end
    reset_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_rd !== 1'b0)    begin n_fail++; $display("FAIL rstmid_mem_rd: got %b, required 0", mem_rd); end
    n_cmp++; if (vid_ack !== 1'b0)   begin n_fail++; $display("FAIL rstmid_vid_ack: got %b, required 0", vid_ack); end
    n_cmp++; if (vid_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_vid_data: got %h, required 00", vid_data); end
    n_cmp++; if (cpu_di !== 8'h00)   begin n_fail++; $display("FAIL rstmid_cpu_di: got %h, required 00", cpu_di); end
    vid_req = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (vid_ack) late_acks++;
    end
    n_cmp++; if (late_acks != 0) begin n_fail++; $display("FAIL rstmid_late_ack: got %0d, required 0", late_acks); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_refresh();
    test_both_strobes();
    test_starvation();
    test_back_to_back();
    test_reset_mid();
    n_cmp++;
    if (vid_q.size() != 0 || cpu_q.size() != 0) begin
      n_fail++; $display("FAIL drain: vid_q=%0d cpu_q=%0d, required 0/0", vid_q.size(), cpu_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, 4, max consecutive video grants while a CPU access waits; range 1..15.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 reset_n  in  1  reset, synchronous, active-low.
REQ-004 cpu_mreq_n  in  1  Z80 memory request, active-low.
REQ-005 cpu_rd_n / cpu_wr_n  in  1 each  Z80 read / write strobes, active-low.
REQ-006 cpu_addr  in  16  CPU address; cpu_dout  in  8  CPU write data.
REQ-007 cpu_di  out  8  registered read data to CPU; cpu_wait_n  out  1  CPU stall, active-low.
REQ-008 vid_req  in  1  video fetch request, level; vid_addr  in  16  video fetch address.
REQ-009 vid_data  out  8  registered fetched byte; vid_ack  out  1  one-cycle pulse, vid_data valid.
REQ-010 mem_addr  out  16; mem_din  out  8; mem_rd  out  1; mem_wr  out  1  memory port, active-high strobes.
REQ-011 mem_dout  in  8  memory read data, valid the cycle after mem_rd is high.

Function
REQ-012 CPU pending = ~cpu_mreq_n & (~cpu_rd_n | ~cpu_wr_n) & ~cpu_done; mreq_n low with both strobes high (refresh) SHALL NOT start an access.
REQ-013 FSM states: IDLE, CPU_RD, CPU_CAP, CPU_WR, VID_RD, VID_CAP; every non-IDLE state lasts exactly one cycle.
REQ-014 IDLE: video pending and (no CPU pending or streak < STARVE_LIMIT) -> VID_RD; else CPU pending -> CPU_RD if ~cpu_rd_n, else CPU_WR; else stay.
REQ-015 cpu_rd_n and cpu_wr_n both low SHALL be served as a read.
REQ-016 CPU_RD: mem_addr=cpu_addr, mem_rd=1 -> CPU_CAP; CPU_CAP: cpu_di<=mem_dout, cpu_done<=1 -> IDLE.
REQ-017 CPU_WR: mem_addr=cpu_addr, mem_din=cpu_dout, mem_wr=1, cpu_done<=1 -> IDLE.
REQ-018 VID_RD: mem_addr=vid_addr, mem_rd=1 -> VID_CAP; VID_CAP: vid_data<=mem_dout, vid_ack<=1 -> IDLE.
REQ-019 vid_ack SHALL be high for exactly the one cycle after VID_CAP; vid_req high in that cycle is a new request.
REQ-020 Video requester holds vid_req and vid_addr stable until vid_ack.
REQ-021 cpu_done SHALL clear on the first edge where cpu_mreq_n is high; an access is served once per mreq_n assertion.
REQ-022 cpu_wait_n = ~(CPU pending), combinational; forced 1 while reset_n low.
REQ-023 Latency, uncontended CPU read seen in IDLE at cycle N: mem_rd at N+1, cpu_di valid and cpu_wait_n high at N+3.
REQ-024 Latency, uncontended CPU write at N: mem_wr at N+1, cpu_wait_n high at N+2.
REQ-025 Latency, video request at N: mem_rd at N+1, vid_ack and vid_data at N+3.
REQ-026 Streak counter: +1 per video grant made while CPU pending, saturates at STARVE_LIMIT, cleared on any CPU grant or when IDLE with no CPU pending.
REQ-027 mem_rd, mem_wr SHALL decode from state register only; never both high; mem_addr=0 and mem_din=0 in IDLE and capture states.
REQ-028 cpu_di and vid_data SHALL hold value until next respective capture.

Reset
REQ-029 reset_n low at an edge: state=IDLE, cpu_done=0, streak=0, vid_ack=0, cpu_di=0, vid_data=0.
REQ-030 Reset mid-access SHALL abort it; mem_rd=mem_wr=0 from the cycle after the reset edge; no capture or ack.

Structure
REQ-031 Package mem_arb_pkg SHALL hold the state enum, ADDR_W=16, DATA_W=8, and the STARVE_LIMIT default.
REQ-032 No sub-module; FSM, streak counter and output mux are inline in mem_arbiter.
REQ-033 Instantiated between tv80s and mem_module; cpu_wait_n drives tv80s wait_n; CPU side uses the core's native active-low strobes.

Verification
REQ-034 CPU read of 0x1234 holding 0xA5, no video -> mem_rd at N+1 with addr 0x1234, cpu_di=0xA5 and cpu_wait_n=1 at N+3.
REQ-035 CPU write 0x5A to 0x8000 -> single mem_wr cycle with addr 0x8000, din 0x5A; a read of 0x8000 then returns 0x5A; no second write during the same mreq_n.
REQ-036 vid_req and CPU read both raised at N, vid_req held with STARVE_LIMIT=4 -> exactly 4 video acks, then a CPU grant, then video resumes.
REQ-037 Refresh cycle (mreq_n=0, rd_n=wr_n=1) -> no mem_rd/mem_wr, cpu_wait_n stays 1.
REQ-038 reset_n low during VID_RD -> no vid_ack, mem_rd=0 next cycle, all outputs at reset values.
REQ-039 Back-to-back video fetches 0x4000..0x4003 -> four acks spaced 3 cycles apart with matching data.
